// File: rtl/washrm_tank_refill_if.sv
// Tank refill handshake bundle between the restroom controller and the
// owner-side refill controller.
interface washrm_tank_refill_if;
   logic       refill_req;
   logic       lvl_low_sns;
   logic       lvl_full_sns;
   logic       fault_clr;
   logic       motor_on;
   logic       water_level;
   logic       refill_busy;
   logic       fault;
   logic [1:0] fault_code;
   logic [7:0] fill_count;

   modport master (
      output refill_req,
      output lvl_low_sns,
      output lvl_full_sns,
      output fault_clr,
      input  motor_on,
      input  water_level,
      input  refill_busy,
      input  fault,
      input  fault_code,
      input  fill_count
   );

   modport slave (
      input  refill_req,
      input  lvl_low_sns,
      input  lvl_full_sns,
      input  fault_clr,
      output motor_on,
      output water_level,
      output refill_busy,
      output fault,
      output fault_code,
      output fill_count
   );
endinterface

// File: rtl/washrm_tank_refill.sv
// Owner-side tank refill controller: Moore FSM with start delay,
// fill timeout, settle re-check, fault latch and refill counter.
module washrm_tank_refill #(
   parameter int START_DLY    = 4,
   parameter int FILL_TIMEOUT = 20,
   parameter int SETTLE_CYC   = 3,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   washrm_tank_refill_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_FILL,
      S_SETTLE,
      S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] START_LIM  = CNT_W'(START_DLY - 1);
   localparam logic [CNT_W-1:0] FILL_LIM   = CNT_W'(FILL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYC - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_nxt;
   logic             r_water;
   logic             w_water_nxt;
   logic [1:0]       r_code;
   logic [1:0]       w_code_nxt;
   logic [7:0]       r_cnt;
   logic [7:0]       w_cnt_nxt;

   logic w_trig;
   logic w_conflict;
   logic w_full;

   assign w_full     = bus.lvl_full_sns;
   assign w_conflict = bus.lvl_low_sns & bus.lvl_full_sns;
   assign w_trig     = (bus.refill_req | bus.lvl_low_sns) & ~w_full;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_water <= 1'b0;
         r_code  <= 2'b00;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         r_timer <= w_timer_nxt;
         r_water <= w_water_nxt;
         r_code  <= w_code_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Sensor conflict pre-empts every non-FAULT state.
   always_comb begin
      w_next = r_state;
      if (w_conflict && r_state != S_FAULT) begin
         w_next = S_FAULT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trig) w_next = S_START;
            end
            S_START: begin
               if (w_full)                  w_next = S_IDLE;
               else if (r_timer == START_LIM) w_next = S_FILL;
            end
            S_FILL: begin
               if (w_full)                   w_next = S_SETTLE;
               else if (r_timer == FILL_LIM) w_next = S_FAULT;
            end
            S_SETTLE: begin
               if (r_timer == SETTLE_LIM)
                  w_next = w_full ? S_IDLE : S_START;
            end
            S_FAULT: begin
               if (bus.fault_clr && !w_conflict) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
      if (w_next != r_state || r_state == S_IDLE || r_state == S_FAULT)
         w_timer_nxt = '0;
      else
         w_timer_nxt = r_timer + 1'b1;
   end

   always_comb begin
      w_water_nxt = r_water;
      w_code_nxt  = r_code;
      w_cnt_nxt   = r_cnt;
      if (w_conflict && r_state != S_FAULT) begin
         w_water_nxt = 1'b0;
         w_code_nxt  = 2'b10;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trig)      w_water_nxt = 1'b0;
               else if (w_full) w_water_nxt = 1'b1;
            end
            S_START: w_water_nxt = 1'b0;
            S_FILL: begin
               w_water_nxt = 1'b0;
               if (!w_full && r_timer == FILL_LIM) w_code_nxt = 2'b01;
            end
            S_SETTLE: begin
               if (r_timer == SETTLE_LIM && w_full) begin
                  w_water_nxt = 1'b1;
                  if (r_cnt != 8'hFF) w_cnt_nxt = r_cnt + 8'd1;
               end
            end
            S_FAULT: begin
               w_water_nxt = 1'b0;
               if (bus.fault_clr) w_code_nxt = w_conflict ? 2'b10 : 2'b00;
            end
            default: w_water_nxt = 1'b0;
         endcase
      end
   end

   assign bus.motor_on    = (r_state == S_FILL);
   assign bus.refill_busy = (r_state == S_START) | (r_state == S_FILL) |
                            (r_state == S_SETTLE);
   assign bus.fault       = (r_state == S_FAULT);
   assign bus.water_level = r_water;
   assign bus.fault_code  = r_code;
   assign bus.fill_count  = r_cnt;

endmodule

// File: doc/washrm_tank_refill.md
# washrm_tank_refill

Owner-side tank refill controller for the smart restroom system. It is the responder to the restroom controller's `water_level_indi_owner` request: it runs the pump motor and supervises the tank level sensors. It returns the `water_level` "tank full" qualifier that gates the restroom door logic. A Moore state machine with start delay, fill timeout, settle check, fault latch and refill counter.

## Interface
Parameters:
- START_DLY, 4: cycles the motor stays off after a refill trigger (anti-chatter), 1 to 2^CNT_W-1
- FILL_TIMEOUT, 20: maximum cycles motor_on may stay high in one fill, 1 to 2^CNT_W-1
- SETTLE_CYC, 3: cycles motor off before re-checking the full sensor, 1 to 2^CNT_W-1
- CNT_W, 16: width of the shared cycle timer

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- refill_req  in  1  owner/restroom refill request; connects to `water_level_indi_owner`
- lvl_low_sns  in  1  tank low-level sensor, 1 = below low mark
- lvl_full_sns  in  1  tank full-level sensor, 1 = at or above full mark
- fault_clr  in  1  owner fault acknowledge, level-sampled
- motor_on  out  1  pump motor drive
- water_level  out  1  tank-usable flag to the restroom controller
- refill_busy  out  1  high in START, FILL or SETTLE
- fault  out  1  high in FAULT
- fault_code  out  2  00 none, 01 fill timeout, 10 sensor conflict; held while in FAULT
- fill_count  out  8  completed refills, saturates at 255

## Operation
- Reset (rst_n=0 at an edge) puts the FSM in IDLE, clears the timer, and clears all outputs: motor_on=0, water_level=0, refill_busy=0, fault=0, fault_code=00, fill_count=0. Reset mid-fill drops the motor on that same edge.
- Trigger: trig = (refill_req | lvl_low_sns) & ~lvl_full_sns.
- Sensor conflict: lvl_low_sns=1 and lvl_full_sns=1 in the same cycle. From any non-FAULT state this goes to FAULT with code 10. It has highest priority.
- IDLE:
  - water_level update: lvl_low_sns=1 → 0; else lvl_full_sns=1 → 1; else hold (hysteresis).
  - trig=1 → START, timer cleared.
  - refill_req with lvl_full_sns=1 is ignored.
- START:
  - motor off, water_level=0.
  - lvl_full_sns=1 → IDLE.
  - When the timer reaches START_DLY-1 → FILL, timer cleared.
- FILL:
  - motor_on=1, water_level=0.
  - lvl_full_sns=1 → SETTLE, timer cleared.
  - Otherwise, timer==FILL_TIMEOUT-1 → FAULT, code 01.
  - Full sensor and timeout on the same edge: full wins → SETTLE.
- SETTLE:
  - motor off.
  - When the timer reaches SETTLE_CYC-1: lvl_full_sns=1 → IDLE, water_level=1, fill_count+1 (saturating); else → START (top-up retry, fill_count unchanged).
- FAULT:
  - motor off, water_level=0, fault=1.
  - fault_clr=1 with sensors non-conflicting → IDLE, fault_code=00.
  - fault_clr=1 while conflict persists → stay in FAULT with code 10.
- Timer is CNT_W bits, cleared on every state change, never wraps (bounded by the parameters).

## Timing
- All outputs are registered and decoded from the state register (Moore). No combinational input-to-output path.
- trig sampled high at edge k → refill_busy=1 after edge k; motor_on=1 after edge k+START_DLY.
- Per fill attempt, motor_on is high at most FILL_TIMEOUT cycles. The fault asserts on the edge after the last motor cycle.
- lvl_full_sns high at edge m in FILL → motor_on=0 after edge m. water_level=1 and the fill_count increment occur after edge m+SETTLE_CYC.
- refill_req only needs to be high for 1 cycle in IDLE. After that the FSM runs on the sensors alone.
- fault_clr at edge n → fault=0 after edge n. A new trigger is honoured from edge n+1.

## Test plan
- Reset during FILL (START_DLY=4, FILL_TIMEOUT=20, SETTLE_CYC=3): rst_n=0 for 1 cycle → motor_on=0 and every output at its reset value on the next cycle; FSM in IDLE.
- Normal refill: lvl_low_sns=1 at edge 0, lvl_full_sns=1 at edge 10.
  - water_level=0 and refill_busy=1 after edge 0.
  - motor_on=1 from edge 4 through edge 9, 0 after edge 10.
  - water_level=1 and fill_count=1 after edge 13.
- Timeout: trigger, full sensor held 0 → motor_on high exactly 20 cycles, then fault=1 with fault_code=01. fault_clr pulse → IDLE; with lvl_low_sns still 1, the next START follows 1 cycle later.
- Sensor conflict: lvl_low_sns=lvl_full_sns=1 during FILL → motor_on=0 and fault_code=10 next cycle. fault_clr while the conflict is held → stays in FAULT; clearing the conflict then pulsing fault_clr → IDLE.
- Settle retry: full sensor pulses 1 for 1 cycle in FILL, then stays 0 → SETTLE 3 cycles → START (fill_count unchanged) → motor on again 4 cycles later.
- Boundaries:
  - refill_req with lvl_full_sns=1 in IDLE → no state change.
  - Full and timeout on the same edge → SETTLE, not FAULT.
  - 256 completed refills → fill_count stays 255.
